// File: rtl/cap_touch_scanner_if.sv
// cap_touch_scanner_if: processor-side register bus of the capacitive pad scanner.
// Control to the scanner: enable, calibrate, touch_delta, ch_sel.
// Status from the scanner: touched, touch_event, scan_done, ch_count.
interface cap_touch_scanner_if #(
  parameter int NUM_CH = 9,
  parameter int CNT_W  = 12
);
  logic              enable;
  logic              calibrate;
  logic [CNT_W-1:0]  touch_delta;
  logic [3:0]        ch_sel;
  logic [CNT_W-1:0]  ch_count;
  logic [NUM_CH-1:0] touched;
  logic [NUM_CH-1:0] touch_event;
  logic              scan_done;
  modport master (
    output enable, calibrate, touch_delta, ch_sel,
    input  ch_count, touched, touch_event, scan_done
  );
  modport slave (
    input  enable, calibrate, touch_delta, ch_sel,
    output ch_count, touched, touch_event, scan_done
  );
endinterface

// File: rtl/cap_touch_scanner.sv
// cap_touch_scanner: times each pad's RC rise on a shared charge line, calibrates baselines, debounces touches.
// clock/reset: rising-edge clock, synchronous active-low reset.
// sensors_in: raw asynchronous pad inputs; sense_out: shared charge drive.
// bus: enable, calibrate, touch_delta, ch_sel in; touched, touch_event, scan_done, ch_count out.
module cap_touch_scanner #(
  parameter int NUM_CH           = 9,
  parameter int CNT_W            = 12,
  parameter int CHARGE_TIMEOUT   = 4095,
  parameter int DISCHARGE_CYCLES = 256,
  parameter int DEBOUNCE         = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sensors_in,
  output logic              sense_out,
  cap_touch_scanner_if.slave bus
);
  // One counter serves both the discharge wait and the charge timing.
  localparam int DW = ($clog2(DISCHARGE_CYCLES) > CNT_W) ? $clog2(DISCHARGE_CYCLES) : CNT_W;
  localparam int BW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, DISCH, CHARGE, EVAL} state_t;
  state_t            state_q, state_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_CH-1:0] latched_q, latched_d, touched_q, touched_d, event_q, event_d, raw;
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [CNT_W-1:0]  base_q [NUM_CH];
  logic [CNT_W-1:0]  base_d [NUM_CH];
  logic [BW-1:0]     db_q [NUM_CH];
  logic [BW-1:0]     db_d [NUM_CH];
  logic              cal_q, cal_d, done_q, done_d;
  assign sense_out       = state_q == CHARGE;
  assign bus.touched     = touched_q;
  assign bus.touch_event = event_q;
  assign bus.scan_done   = done_q;
  assign bus.ch_count    = (32'(bus.ch_sel) < NUM_CH) ? count_q[bus.ch_sel] : '0;
  // Threshold compare one bit wider so baseline + delta cannot wrap.
  always_comb begin
    raw = '0;
    for (int c = 0; c < NUM_CH; c++)
      raw[c] = {1'b0, count_q[c]} > ({1'b0, base_q[c]} + {1'b0, bus.touch_delta});
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sync1_d   = sensors_in;
    sync2_d   = sync1_q;
    latched_d = latched_q;
    touched_d = touched_q;
    event_d   = '0;
    done_d    = 1'b0;
    cal_d     = cal_q;
    count_d   = count_q;
    base_d    = base_q;
    db_d      = db_q;
    case (state_q)
      IDLE: begin
        state_d = bus.enable ? DISCH : IDLE;
        cnt_d   = '0;
      end
      DISCH: begin
        state_d   = (cnt_q == DW'(DISCHARGE_CYCLES - 1)) ? CHARGE : DISCH;
        cnt_d     = (cnt_q == DW'(DISCHARGE_CYCLES - 1)) ? '0 : cnt_q + DW'(1);
        latched_d = '0;
      end
      CHARGE: begin
        cnt_d = cnt_q + DW'(1);
        for (int c = 0; c < NUM_CH; c++)
          if (!latched_q[c] && sync2_q[c]) begin
            latched_d[c] = 1'b1;
            count_d[c]   = cnt_q[CNT_W-1:0];
          end
        if (&latched_d || cnt_q == DW'(CHARGE_TIMEOUT)) begin
          state_d = EVAL;
          for (int c = 0; c < NUM_CH; c++)
            if (!latched_d[c]) count_d[c] = CNT_W'(CHARGE_TIMEOUT);
        end
      end
      default: begin
        state_d = bus.enable ? DISCH : IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (cal_q) begin
          base_d = count_q;
          cal_d  = 1'b0;
        end else
          for (int c = 0; c < NUM_CH; c++)
            if (raw[c] == touched_q[c]) db_d[c] = '0;
            else if (db_q[c] == BW'(DEBOUNCE - 1)) begin
              touched_d[c] = raw[c];
              db_d[c]      = '0;
            end else db_d[c] = db_q[c] + BW'(1);
        event_d = touched_d & ~touched_q;
      end
    endcase
    // A request arriving during EVAL survives for the next scan.
    if (bus.calibrate) cal_d = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      latched_q <= '0;
      touched_q <= '0;
      event_q   <= '0;
      done_q    <= 1'b0;
      cal_q     <= 1'b1;
      count_q   <= '{default: '0};
      base_q    <= '{default: '0};
      db_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      latched_q <= latched_d;
      touched_q <= touched_d;
      event_q   <= event_d;
      done_q    <= done_d;
      cal_q     <= cal_d;
      count_q   <= count_d;
      base_q    <= base_d;
      db_q      <= db_d;
    end
  end
endmodule

// File: tb/tb_cap_touch_scanner.sv
// tb_cap_touch_scanner: directed scans of the pad scanner with hand-computed counts and touch states.
`timescale 1ns/1ns
module tb_cap_touch_scanner;
  localparam int NCH = 9;
  localparam int CW  = 8;
  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] sensors_in = '0;
  logic           sense_out;
  int             checks = 0;
  int             failures = 0;
  int             pad_n [NCH];
  int             drop_en_at = -1;
  cap_touch_scanner_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();
  cap_touch_scanner #(
    .NUM_CH(NCH), .CNT_W(CW), .CHARGE_TIMEOUT(255), .DISCHARGE_CYCLES(8), .DEBOUNCE(3)
  ) dut (
    .clock(clock), .reset(reset), .sensors_in(sensors_in), .sense_out(sense_out), .bus(bus)
  );
  always #20 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic cnt_chk(input int ch, input int exp);
    bus.ch_sel = 4'(ch);
    #1;
    chk($sformatf("count%0d", ch), 32'(bus.ch_count), exp);
  endtask
  // Runs one scan, raising each pad pad_n[c] cycles into CHARGE; returns in the scan_done cycle.
  task automatic scan(input string tag);
    int k, guard;
    guard = 0;
    while (!sense_out && guard < 600) begin
      tick;
      guard++;
    end
    if (!sense_out) begin
      chk({tag, "_start"}, 32'(sense_out), 1);
      return;
    end
    k = 0;
    while (sense_out && k < 400) begin
      for (int c = 0; c < NCH; c++) if (pad_n[c] == k) sensors_in[c] = 1'b1;
      if (k == drop_en_at) bus.enable = 1'b0;
      tick;
      k++;
    end
    tick;
    chk({tag, "_done"}, 32'(bus.scan_done), 1);
    sensors_in = '0;
  endtask
  task automatic state_chk(input string tag, input int t, input int e);
    chk({tag, "_touched"}, 32'(bus.touched), t);
    chk({tag, "_event"}, 32'(bus.touch_event), e);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int hi;
    bus.enable = 1'b0;
    bus.calibrate = 1'b0;
    bus.touch_delta = 8'd10;
    bus.ch_sel = 4'd0;
    for (int c = 0; c < NCH; c++) pad_n[c] = 20;
    repeat (3) tick;
    chk("rst_sense", 32'(sense_out), 0);
    state_chk("rst", 0, 0);
    chk("rst_done", 32'(bus.scan_done), 0);
    cnt_chk(0, 0);
    reset = 1'b1;
    bus.enable = 1'b1;
    scan("cal");
    state_chk("cal", 0, 0);
    for (int c = 0; c < NCH; c++) cnt_chk(c, 22);
    cnt_chk(9, 0);
    cnt_chk(15, 0);
    tick;
    chk("done_pulse", 32'(bus.scan_done), 0);
    pad_n[4] = 40;
    for (int s = 1; s <= 3; s++) begin
      scan("touch");
      state_chk($sformatf("touch%0d", s), s == 3 ? 'h010 : 0, s == 3 ? 'h010 : 0);
    end
    cnt_chk(4, 42);
    tick;
    state_chk("touch_after", 'h010, 0);
    pad_n[4] = 20;
    for (int s = 1; s <= 3; s++) begin
      scan("release");
      state_chk($sformatf("release%0d", s), s == 3 ? 0 : 'h010, 0);
    end
    pad_n[4] = 30;
    for (int s = 1; s <= 10; s++) begin
      scan("thresh");
      if (s == 1) cnt_chk(4, 32);
      chk($sformatf("thresh%0d", s), 32'(bus.touched), 0);
    end
    for (int s = 1; s <= 5; s++) begin
      pad_n[4] = s <= 2 ? 40 : 20;
      scan("glitch");
      chk($sformatf("glitch%0d", s), 32'(bus.touched), 0);
    end
    pad_n[4] = 20;
    pad_n[2] = -1;
    for (int s = 1; s <= 3; s++) begin
      scan("timeout");
      if (s == 1) cnt_chk(2, 255);
      state_chk($sformatf("timeout%0d", s), s == 3 ? 'h004 : 0, s == 3 ? 'h004 : 0);
    end
    pad_n[2] = 20;
    drop_en_at = 5;
    scan("endrop");
    drop_en_at = -1;
    chk("endrop_touched", 32'(bus.touched), 'h004);
    hi = 0;
    repeat (60) begin
      tick;
      if (sense_out || bus.scan_done) hi++;
    end
    chk("idle_quiet", hi, 0);
    bus.enable = 1'b1;
    pad_n[4] = 40;
    hi = 0;
    while (!sense_out && hi < 100) begin
      tick;
      hi++;
    end
    chk("rstmid_charge", 32'(sense_out), 1);
    repeat (10) tick;
    reset = 1'b0;
    tick;
    chk("rstmid_sense", 32'(sense_out), 0);
    chk("rstmid_touched", 32'(bus.touched), 0);
    chk("rstmid_done", 32'(bus.scan_done), 0);
    reset = 1'b1;
    sensors_in = '0;
    for (int s = 1; s <= 4; s++) begin
      scan("recal");
      state_chk($sformatf("recal%0d", s), 0, 0);
    end
    pad_n[4] = 20;
    tick;
    bus.calibrate = 1'b1;
    tick;
    bus.calibrate = 1'b0;
    scan("calreq");
    state_chk("calreq", 0, 0);
    pad_n[4] = 40;
    for (int s = 1; s <= 3; s++) begin
      scan("aftercal");
      state_chk($sformatf("aftercal%0d", s), s == 3 ? 'h010 : 0, s == 3 ? 'h010 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
